uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receive front end for the debug block: converts the RS-232 RXD line into bytes buffered in a small FIFO.
- Sits between the top-level RS232_DCE_RXD pin and the debugger command parser, which pops bytes with a read strobe.
- Runs on the 50 MHz system clock; no other clock domains.

Parameters:
- SYS_CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 38400, serial bit rate.
- FIFO_ADDR_BITS, 3, log2 of FIFO depth (default depth 8).

Ports:
- clk  in  1  system clock; the single clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input, idle high, 8 data bits LSB first, 1 stop bit.
- rd_en  in  1  pops the FIFO head; ignored when rx_empty=1.
- rx_data  out  8  FIFO head (first-word fall-through); 0x00 when empty.
- rx_empty  out  1  FIFO holds no bytes.
- rx_full  out  1  FIFO holds 2^FIFO_ADDR_BITS bytes.
- overflow  out  1  one-cycle pulse: received byte dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse: stop bit sampled low; byte discarded.

Behaviour:
- Reset values: rx_data=0x00, rx_empty=1, rx_full=0, overflow=0, frame_err=0. The FIFO is emptied, the FSM enters IDLE, and the synchronizer flops preset to 1.
- rx passes through a 2-flop synchronizer. All FSM decisions use the synchronized value.
- Oversample tick: DIV = SYS_CLK_FREQ/(BAUD_RATE*16), integer truncated (81 at defaults). The tick counter runs 0..DIV-1 and pulses tick when it reaches DIV-1. The counter and the tick count are cleared on entry to START.
- FSM states:
  - IDLE: synchronized rx==0 -> START.
  - START: on the 8th tick (mid start bit), sample rx. If rx==1 (glitch) -> IDLE; else -> DATA with bit_idx=0.
  - DATA: every 16th tick, sample rx into shift[bit_idx]. After bit_idx=7 -> STOP.
  - STOP: on the 16th tick, sample rx.
    - rx==1: push the byte -> IDLE.
    - rx==0: pulse frame_err, discard -> BREAK.
  - BREAK: wait for synchronized rx==1 -> IDLE. A held-low line never produces bytes.
- Push timing: the byte is written on the clock edge following the stop-bit sample cycle. rx_empty drops and rx_data is valid on the next cycle (1-cycle latency).
- FIFO:
  - Pointers are FIFO_ADDR_BITS+1 wide and wrap naturally.
  - Full: pointer MSBs differ and the low bits are equal.
  - Pop when empty: no effect.
  - Push when full without rd_en: byte dropped and overflow pulses; stored contents are unchanged.
  - Push and rd_en in the same cycle when full: pop and push both occur, count stays full, no overflow.
  - Push and rd_en in the same cycle when empty: the push occurs and the pop is ignored.
- rst asserted mid-frame: the FSM returns to IDLE immediately, the partial byte is discarded and the FIFO is cleared.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP and samples an even-parity bit. A mismatch still completes STOP but discards the byte and pulses frame_err; BREAK is entered only if the stop bit is low.
- Undefined: 8N1 only; there is no PARITY state or logic.

Decomposition:
- Shared include (uart_defs): FSM state encodings, OVERSAMPLE=16, START_SAMPLE_TICK=8.
- Sub-module uart_rx_fifo: parameterized synchronous FIFO (push, pop, full, empty, first-word fall-through head). It is reusable by a later uart_tx.

Test Plan (SYS_CLK_FREQ=1600000, BAUD_RATE=10000, so DIV=10 and 160 clk/bit):
- Send 0xA5 8N1 -> rx_empty=0 and rx_data=0xA5 one cycle after the stop-bit sample; rd_en for one cycle -> rx_empty=1, rx_data=0x00.
- Hold rx low for 30 clk, then high -> no push, no frame_err, FSM back in IDLE; a following 0x5A is received correctly.
- Send 0x3C with a low stop bit, then hold rx low 400 clk -> one frame_err pulse, FIFO empty, no further pulses until rx returns high; a next 0x11 is received.
- Send 0x00..0x08 with no reads -> rx_full=1 after 0x07, overflow pulses on 0x08; eight pops return 0x00..0x07.
- With the FIFO full, assert rd_en in the push cycle of 0x09 -> no overflow, rx_full stays 1, the last pop yields 0x09.
- Assert rst mid-way through data bit 4 of 0xFF -> all outputs at reset values; a subsequent 0x81 is received intact.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the UART receive path.
//   - FSM state encodings (plain localparam constants, 3 bits wide)
//   - OVERSAMPLE ticks per bit and the start-bit mid-point tick
//   - calc_div: oversample divider from clock and baud rate
// Related build option: UART_RX_PARITY_EN (see uart_rx.sv).
package uart_rx_pkg;

    localparam int OVERSAMPLE        = 16;
    localparam int START_SAMPLE_TICK = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    // Integer-truncated clocks per oversample tick.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst    single clock, synchronous active-high reset (empties FIFO)
//   push        write push_data this cycle
//   push_data   byte to store
//   pop         remove the head; ignored while empty
//   head        current head entry, all zeros when empty
//   empty/full  occupancy flags
//   overflow    registered one-cycle pulse when a push was dropped
// A push into a full FIFO succeeds only when a pop happens in the same
// cycle; a pop on an empty FIFO is ignored even if a push arrives with it.
module uart_rx_fifo #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_BITS:0] wr_ptr;
    logic [ADDR_BITS:0] rd_ptr;
    logic               do_pop;
    logic               do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                     (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot being overwritten.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[ADDR_BITS-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && !do_push;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[ADDR_BITS-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: RS-232 receive front end with a byte FIFO.
// Frame: idle high, start bit, 8 data bits LSB first, 1 stop bit.
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit
// between the data and stop bits.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   rx         asynchronous serial line
//   rd_en      pop the FIFO head (ignored while empty)
//   rx_data    FIFO head, 0x00 when empty
//   rx_empty   FIFO empty
//   rx_full    FIFO full
//   overflow   one-cycle pulse: received byte dropped, FIFO full
//   frame_err  one-cycle pulse: bad stop (or parity) bit, byte dropped
// The FSM state is kept in the named signal `state` for observation.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int SYS_CLK_FREQ   = 50000000,
    parameter int BAUD_RATE      = 38400,
    parameter int FIFO_ADDR_BITS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       overflow,
    output logic       frame_err
);

    localparam int DIV   = calc_div(SYS_CLK_FREQ, BAUD_RATE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [3:0] START_LAST = 4'(START_SAMPLE_TICK - 1);
    localparam logic [3:0] BIT_LAST   = 4'(OVERSAMPLE - 1);

    logic             rx_meta;
    logic             rx_sync;
    logic [2:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       tick_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             bit_end;
    logic             byte_push;
    logic             byte_ok;

    // Two-flop synchronizer, preset to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Oversample divider, realigned to the start-bit falling edge.
    always_ff @(posedge clk) begin
        if (rst || (state == ST_IDLE && !rx_sync)) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick    = (div_cnt == DIV_LAST);
    assign bit_end = tick && (tick_cnt == BIT_LAST);

`ifdef UART_RX_PARITY_EN
    logic parity_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (state == ST_PARITY && bit_end) begin
            // Even parity: the parity bit equals the XOR of the data bits.
            parity_err <= (^shift) ^ rx_sync;
        end
    end

    assign byte_ok = !parity_err;
`else
    assign byte_ok = 1'b1;
`endif

    assign byte_push = (state == ST_STOP) && bit_end && rx_sync && byte_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (tick) begin
                tick_cnt <= tick_cnt + 4'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (!rx_sync) begin
                        state    <= ST_START;
                        tick_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (tick && tick_cnt == START_LAST) begin
                        // From mid start bit, each further 16 ticks is mid-bit.
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rx_sync ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift[bit_idx] <= rx_sync;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        if (rx_sync) begin
                            frame_err <= !byte_ok;
                            state     <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    // A held-low line must return high before a new frame.
                    if (rx_sync) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH     (8),
        .ADDR_BITS (FIFO_ADDR_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (byte_push),
        .push_data (shift),
        .pop       (rd_en),
        .head      (rx_data),
        .empty     (rx_empty),
        .full      (rx_full),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at 1.6 MHz / 10 kbaud
// (10 clocks per tick, 160 clocks per bit).
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int BIT_CLKS = 160;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       rd_en;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_full;
    logic       overflow;
    logic       frame_err;

    int total;
    int bad;
    int fe_cnt;
    int ov_cnt;
    logic [7:0] exp_q[$];

    uart_rx #(
        .SYS_CLK_FREQ   (1600000),
        .BAUD_RATE      (10000),
        .FIFO_ADDR_BITS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rd_en     (rd_en),
        .rx_data   (rx_data),
        .rx_empty  (rx_empty),
        .rx_full   (rx_full),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitors
    always @(negedge clk) begin
        if (!rst && frame_err) fe_cnt++;
        if (!rst && overflow)  ov_cnt++;
    end

    // Driver tasks
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(BIT_CLKS);
        end
        rx = stop;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_byte(input logic [7:0] d);
        drive_frame(d, 1'b1);
        rx = 1'b1;
        wait_clks(20);
    endtask

    // Scoreboard consumer: pop one byte and compare with the queue head.
    task automatic sb_pop(input string name);
        logic [7:0] exp;
        total++;
        if (rx_empty !== 1'b0) begin
            bad++;
            $display("FAIL %s empty: got %b want 0", name, rx_empty);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        total++;
        if (rx_data !== exp) begin
            bad++;
            $display("FAIL %s data: got %02h want %02h", name, rx_data, exp);
        end
        rd_en = 1'b1;
        wait_clks(1);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx = 1'b1;
        rd_en = 1'b0;
        wait_clks(4);
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset rx_data: got %02h want 00", rx_data); end
        total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL reset rx_empty: got %b want 1", rx_empty); end
        total++; if (rx_full !== 1'b0) begin bad++; $display("FAIL reset rx_full: got %b want 0", rx_full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset overflow: got %b want 0", overflow); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset frame_err: got %b want 0", frame_err); end
        rst = 1'b0;
        wait_clks(20);
    endtask

    task automatic test_basic();
        logic [7:0] d;
        int lat;
        d = 8'hA5;
        // Start and data bits, then measure stop-bit-to-push latency.
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(BIT_CLKS);
        end
        rx = 1'b1;
        exp_q.push_back(d);
        lat = 0;
        while (rx_empty && lat < 2 * BIT_CLKS) begin
            wait_clks(1);
            lat++;
        end
        // Stop sample lands mid stop bit (~80 clk plus synchronizer delay).
        total++;
        if (lat < 80 || lat > 86) begin
            bad++;
            $display("FAIL basic latency: got %0d clk want 80..86", lat);
        end
        wait_clks(BIT_CLKS);
        sb_pop("basic_a5");
        total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL basic empty_after_pop: got %b want 1", rx_empty); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL basic data_after_pop: got %02h want 00", rx_data); end
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = fe_cnt;
        rx = 1'b0;
        wait_clks(30);
        rx = 1'b1;
        wait_clks(200);
        total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL glitch empty: got %b want 1", rx_empty); end
        total++; if (fe_cnt !== fe0) begin bad++; $display("FAIL glitch frame_err: got %0d pulses want 0", fe_cnt - fe0); end
        total++; if (dut.state !== ST_IDLE) begin bad++; $display("FAIL glitch state: got %0d want %0d", dut.state, ST_IDLE); end
        exp_q.push_back(8'h5A);
        send_byte(8'h5A);
        sb_pop("glitch_5a");
    endtask

    task automatic test_break();
        int fe0;
        fe0 = fe_cnt;
        drive_frame(8'h3C, 1'b0);
        rx = 1'b0;
        wait_clks(400);
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL break frame_err: got %0d pulses want 1", fe_cnt - fe0); end
        total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL break empty: got %b want 1", rx_empty); end
        total++; if (dut.state !== ST_BREAK) begin bad++; $display("FAIL break state: got %0d want %0d", dut.state, ST_BREAK); end
        rx = 1'b1;
        wait_clks(20);
        total++; if (dut.state !== ST_IDLE) begin bad++; $display("FAIL break idle: got %0d want %0d", dut.state, ST_IDLE); end
        exp_q.push_back(8'h11);
        send_byte(8'h11);
        sb_pop("break_11");
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL break frame_err_after: got %0d pulses want 1", fe_cnt - fe0); end
    endtask

    task automatic test_overflow();
        int ov0;
        ov0 = ov_cnt;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i));
            total++;
            if (rx_full !== (i == 7)) begin
                bad++;
                $display("FAIL overflow full_after_%0d: got %b want %b", i, rx_full, (i == 7));
            end
        end
        send_byte(8'h08);
        total++; if (ov_cnt - ov0 !== 1) begin bad++; $display("FAIL overflow pulses: got %0d want 1", ov_cnt - ov0); end
        for (int i = 0; i < 8; i++) sb_pop("overflow_drain");
        total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL overflow empty_after: got %b want 1", rx_empty); end
    endtask

    task automatic test_full_rdwr();
        int ov0;
        bit found;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i));
        end
        ov0 = ov_cnt;
        found = 1'b0;
        fork
            send_byte(8'h09);
            begin
                for (int k = 0; k < 2000 && !found; k++) begin
                    @(negedge clk);
                    if (dut.byte_push) begin
                        found = 1'b1;
                        sb_pop("rdwr_pop");
                    end
                end
            end
        join
        exp_q.push_back(8'h09);
        total++; if (!found) begin bad++; $display("FAIL rdwr push_seen: got 0 want 1"); end
        total++; if (ov_cnt !== ov0) begin bad++; $display("FAIL rdwr overflow: got %0d pulses want 0", ov_cnt - ov0); end
        total++; if (rx_full !== 1'b1) begin bad++; $display("FAIL rdwr full: got %b want 1", rx_full); end
        for (int i = 0; i < 8; i++) sb_pop("rdwr_drain");
        total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL rdwr empty_after: got %b want 1", rx_empty); end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h42);
        // 0xFF: start bit, data bits 0..3, then half of bit 4.
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        rx = 1'b1;
        wait_clks(4 * BIT_CLKS + BIT_CLKS / 2);
        rst = 1'b1;
        wait_clks(2);
        exp_q.delete();
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rstmid rx_data: got %02h want 00", rx_data); end
        total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL rstmid rx_empty: got %b want 1", rx_empty); end
        total++; if (rx_full !== 1'b0) begin bad++; $display("FAIL rstmid rx_full: got %b want 0", rx_full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rstmid overflow: got %b want 0", overflow); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rstmid frame_err: got %b want 0", frame_err); end
        total++; if (dut.state !== ST_IDLE) begin bad++; $display("FAIL rstmid state: got %0d want %0d", dut.state, ST_IDLE); end
        rst = 1'b0;
        wait_clks(3 * BIT_CLKS + BIT_CLKS / 2 + BIT_CLKS);
        total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL rstmid no_byte: got %b want 1", rx_empty); end
        exp_q.push_back(8'h81);
        send_byte(8'h81);
        sb_pop("rstmid_81");
    endtask

    initial begin
        total = 0;
        bad = 0;
        fe_cnt = 0;
        ov_cnt = 0;
        rst = 1'b1;
        rx = 1'b1;
        rd_en = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_overflow();
        test_full_rdwr();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
